// File: rtl/voxel_stepper.sv
// Voxel grid traversal stepper (Amanatides-Woo style).
// Emits one voxel per handshake until hit, out-of-bounds or step limit.
module voxel_stepper #(
  parameter int COORD_W   = 6,
  parameter int T_W       = 16,
  parameter int MAX_STEPS = 96
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [COORD_W-1:0] ix0,
  input  logic [COORD_W-1:0] iy0,
  input  logic [COORD_W-1:0] iz0,
  input  logic               neg_x,
  input  logic               neg_y,
  input  logic               neg_z,
  input  logic [T_W-1:0]     tmax_x,
  input  logic [T_W-1:0]     tmax_y,
  input  logic [T_W-1:0]     tmax_z,
  input  logic [T_W-1:0]     tdelta_x,
  input  logic [T_W-1:0]     tdelta_y,
  input  logic [T_W-1:0]     tdelta_z,
  output logic [COORD_W-1:0] ix,
  output logic [COORD_W-1:0] iy,
  output logic [COORD_W-1:0] iz,
  input  logic               oob,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               hit,
  output logic               done,
  output logic [1:0]         done_reason
);

  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(MAX_STEPS - 1);

  localparam logic [1:0] R_HIT = 2'b00;
  localparam logic [1:0] R_OOB = 2'b01;
  localparam logic [1:0] R_MAX = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [COORD_W-1:0] cx_q;
  logic [COORD_W-1:0] cy_q;
  logic [COORD_W-1:0] cz_q;
  logic [T_W-1:0]     tmx_q;
  logic [T_W-1:0]     tmy_q;
  logic [T_W-1:0]     tmz_q;
  logic [T_W-1:0]     tdx_q;
  logic [T_W-1:0]     tdy_q;
  logic [T_W-1:0]     tdz_q;
  logic               nx_q;
  logic               ny_q;
  logic               nz_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         reason_q;
  logic [1:0]         reason_d;

  logic load;
  logic adv;
  logic sel_x;
  logic sel_y;
  logic sel_z;

  // Saturating add keeps a far-away axis from wrapping to "nearest".
  function automatic logic [T_W-1:0] sat_add(
    input logic [T_W-1:0] a,
    input logic [T_W-1:0] b
  );
    logic [T_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[T_W] ? {T_W{1'b1}} : s[T_W-1:0];
  endfunction

  function automatic logic [COORD_W-1:0] step_c(
    input logic [COORD_W-1:0] c,
    input logic               neg
  );
    return neg ? c - COORD_W'(1) : c + COORD_W'(1);
  endfunction

  // Smallest tmax wins; ties favour x, then y.
  always_comb begin
    sel_x = (tmx_q <= tmy_q) && (tmx_q <= tmz_q);
    sel_y = !sel_x && (tmy_q <= tmz_q);
    sel_z = !sel_x && !sel_y;
  end

  assign start_ready = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_EMIT) && !oob;
  assign done        = (state_q == S_DONE);
  assign done_reason = done ? reason_q : 2'b00;
  assign ix          = cx_q;
  assign iy          = cy_q;
  assign iz          = cz_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      reason_q <= R_HIT;
    end else begin
      state_q  <= state_d;
      reason_q <= reason_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    reason_d = reason_q;
    load     = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          load    = 1'b1;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (oob) begin
          state_d  = S_DONE;
          reason_d = R_OOB;
        end else if (out_ready) begin
          if (hit) begin
            state_d  = S_DONE;
            reason_d = R_HIT;
          end else if (cnt_q == LAST) begin
            state_d  = S_DONE;
            reason_d = R_MAX;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q  <= '0;
      cy_q  <= '0;
      cz_q  <= '0;
      tmx_q <= '0;
      tmy_q <= '0;
      tmz_q <= '0;
      tdx_q <= '0;
      tdy_q <= '0;
      tdz_q <= '0;
      nx_q  <= 1'b0;
      ny_q  <= 1'b0;
      nz_q  <= 1'b0;
      cnt_q <= '0;
    end else if (load) begin
      cx_q  <= ix0;
      cy_q  <= iy0;
      cz_q  <= iz0;
      tmx_q <= tmax_x;
      tmy_q <= tmax_y;
      tmz_q <= tmax_z;
      tdx_q <= tdelta_x;
      tdy_q <= tdelta_y;
      tdz_q <= tdelta_z;
      nx_q  <= neg_x;
      ny_q  <= neg_y;
      nz_q  <= neg_z;
      cnt_q <= '0;
    end else if (adv) begin
      cnt_q <= cnt_q + CNT_W'(1);
      unique case (1'b1)
        sel_x: begin
          cx_q  <= step_c(cx_q, nx_q);
          tmx_q <= sat_add(tmx_q, tdx_q);
        end
        sel_y: begin
          cy_q  <= step_c(cy_q, ny_q);
          tmy_q <= sat_add(tmy_q, tdy_q);
        end
        sel_z: begin
          cz_q  <= step_c(cz_q, nz_q);
          tmz_q <= sat_add(tmz_q, tdz_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/voxel_stepper.md
VOXEL_STEPPER -- requirements
Module: voxel_stepper

Interface
REQ-001 Parameter COORD_W, default 6, voxel coordinate width.
REQ-002 Parameter T_W, default 16, unsigned fixed-point ray-parameter width.
REQ-003 Parameter MAX_STEPS, default 96, visit limit per ray; must be at least 1.
REQ-004 Port clk, in, 1: single clock; all state updates on rising edge.
REQ-005 Port rst, in, 1: reset, synchronous, active-high.
REQ-006 Port start_valid, in, 1: ray setup valid.
REQ-007 Port start_ready, out, 1: block accepts a ray.
REQ-008 Ports ix0/iy0/iz0, in, COORD_W each: entry voxel.
REQ-009 Ports neg_x/neg_y/neg_z, in, 1 each: step direction; 1 = decrement, 0 = increment.
REQ-010 Ports tmax_x/tmax_y/tmax_z, in, T_W each: initial next-boundary t per axis.
REQ-011 Ports tdelta_x/tdelta_y/tdelta_z, in, T_W each: t increment per axis step.
REQ-012 Ports ix/iy/iz, out, COORD_W each: current voxel; these drive the downstream bounds checker and occupancy lookup.
REQ-013 Port oob, in, 1: out_of_bounds from the bounds checker, combinational on ix/iy/iz.
REQ-014 Port out_valid, out, 1: current voxel offered downstream.
REQ-015 Port out_ready, in, 1: downstream accepts the voxel.
REQ-016 Port hit, in, 1: the accepted voxel is occupied; sampled only on a handshake.
REQ-017 Port done, out, 1: one-cycle termination pulse.
REQ-018 Port done_reason, out, 2: 00 HIT, 01 OOB, 10 MAX_STEPS; valid only while done=1.

Function
REQ-019 FSM states: IDLE, EMIT, DONE.
REQ-020 IDLE: start_ready=1 and out_valid=0.
REQ-021 IDLE, start_valid=1: latch all setup inputs, clear step_cnt, then go to EMIT the next cycle.
REQ-022 EMIT: start_ready=0; ix/iy/iz reflect the registered current voxel.
REQ-023 EMIT with oob=1: out_valid=0; next state DONE with reason OOB. oob has priority over every other condition.
REQ-024 EMIT with oob=0: out_valid=1.
REQ-025 Stall: with out_valid=1 and out_ready=0, ix/iy/iz, the tmax values and step_cnt hold unchanged.
REQ-026 Handshake (out_valid and out_ready) with hit=1: next state DONE with reason HIT; the coordinate does not advance.
REQ-027 Handshake with hit=0 and step_cnt==MAX_STEPS-1: next state DONE with reason MAX_STEPS.
REQ-028 Handshake, any other case:
 - step_cnt increments.
 - Step the axis with the smallest tmax; ties resolve x over y over z.
 - Stay in EMIT.
REQ-029 Axis step: coordinate +1 or -1 modulo 2^COORD_W. 0 decrements to all-ones and all-ones increments to 0; the bounds checker flags these wraps.
REQ-030 Axis step: tmax += tdelta, saturating at 2^T_W-1. Unstepped axes are unchanged.
REQ-031 DONE: done=1 and done_reason driven for exactly one cycle, out_valid=0, start_ready=0; then return to IDLE.
REQ-032 start_valid outside IDLE is ignored, with no state change.
REQ-033 One voxel is emitted per cycle when out_ready is held high.

Reset
REQ-034 rst=1 at a clock edge, in any state, forces IDLE.
REQ-035 rst=1 clears step_cnt, ix/iy/iz, and all tmax/tdelta registers.
REQ-036 After reset: start_ready=1, out_valid=0, done=0, done_reason=00. Any in-flight ray is discarded.

Verification
REQ-037 Start (0,0,0), all positive, tmax=(1,2,3), tdelta=(4,4,4), out_ready=1, hit=0, MAX_STEPS=96.
 - Emitted sequence: (0,0,0), (1,0,0), (1,1,0), (1,1,1), (2,1,1), ...
 - Terminates with done_reason=01 after (31,31,31) steps x to 32.
REQ-038 Start (5,5,5), tmax all 10, tdelta all 1.
 - Tie order: (5,5,5), (6,5,5), (6,6,5), (6,6,6).
 - hit=1 on the 4th handshake -> done_reason=00; ix/iy/iz stay at (6,6,6).
REQ-039 Start (0,3,3) with neg_x=1 and x tmin.
 - Second voxel is x=63 (wrap), oob=1, out_valid=0.
 - Next cycle: done=1, done_reason=01.
REQ-040 MAX_STEPS=4, start (10,10,10), never oob, hit=0: exactly 4 handshakes, then done_reason=10.
REQ-041 Stall and abort:
 - out_ready=0 for 5 cycles mid-ray: outputs held stable.
 - Assert start_valid during the stall: ignored.
 - Assert rst mid-ray: next cycle start_ready=1, out_valid=0, done never pulses.
REQ-042 tmax_x=0xFFF0, tdelta_x=0x0020: after the x step, tmax_x=0xFFFF (saturated).
